// File: rtl/lms_canceller.sv
// rtl/lms_canceller.sv - adaptive LMS hum canceller: TAPS-tap FIR then LMS update on one shared multiplier
// Optional feature macro: LMS_FREEZE_EN adds a freeze input that holds the weights.
module lms_canceller #(
  parameter int TAPS     = 8,
  parameter int MU_SHIFT = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic signed [23:0] d_in,
  input  logic signed [23:0] ref_in,
`ifdef LMS_FREEZE_EN
  input  logic               freeze,
`endif
  output logic               in_ready,
  output logic signed [23:0] data_out,
  output logic               out_valid,
  output logic               overrun
);

  localparam int KW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(TAPS - 1);
  localparam int UPD_SHIFT = 23 + MU_SHIFT;

  typedef enum logic [1:0] {IDLE, FILTER, ERR, UPDATE} state_t;

  state_t             state_q, state_d;
  logic [KW-1:0]      k_q, k_d;
  logic signed [23:0] x_q [TAPS];
  logic signed [23:0] x_d [TAPS];
  logic signed [23:0] w_q [TAPS];
  logic signed [23:0] w_d [TAPS];
  logic signed [53:0] acc_q, acc_d;
  logic signed [23:0] dlat_q, dlat_d;
  logic signed [23:0] e_q, e_d;
  logic signed [23:0] data_out_q, data_out_d;
  logic               out_valid_q, out_valid_d;
  logic               overrun_q, overrun_d;

  logic               frz;
  logic signed [23:0] mul_a;
  logic signed [23:0] x_k;
  logic signed [47:0] prod;
  logic signed [53:0] prod_x;
  logic signed [23:0] y_sat;
  logic signed [53:0] diff;
  logic signed [23:0] e_new;
  logic signed [53:0] w_sum;
  logic signed [23:0] w_new;

  function automatic logic signed [53:0] sx(input logic signed [23:0] v);
    return {{30{v[23]}}, v};
  endfunction

  function automatic logic signed [23:0] sat24(input logic signed [53:0] v);
    if (v > 54'sd8388607)
      return 24'sh7fffff;
    else if (v < -54'sd8388608)
      return 24'sh800000;
    else
      return v[23:0];
  endfunction

`ifdef LMS_FREEZE_EN
  assign frz = freeze;
`else
  assign frz = 1'b0;
`endif

  // The single multiplier sees w[k] while filtering and the error e while updating.
  assign x_k    = x_q[k_q];
  assign mul_a  = (state_q == UPDATE) ? e_q : w_q[k_q];
  assign prod   = mul_a * x_k;
  assign prod_x = {{6{prod[47]}}, prod};

  assign y_sat  = sat24(acc_q >>> 23);
  assign diff   = sx(dlat_q) - sx(y_sat);
  assign e_new  = sat24(diff);

  assign w_sum  = sx(w_q[k_q]) + (prod_x >>> UPD_SHIFT);
  assign w_new  = sat24(w_sum);

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    x_d         = x_q;
    w_d         = w_q;
    acc_d       = acc_q;
    dlat_d      = dlat_q;
    e_d         = e_q;
    data_out_d  = data_out_q;
    out_valid_d = 1'b0;
    overrun_d   = overrun_q | (in_valid & (state_q != IDLE));
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d[0] = ref_in;
          for (int i = 1; i < TAPS; i++) x_d[i] = x_q[i-1];
          dlat_d  = d_in;
          acc_d   = '0;
          k_d     = '0;
          state_d = FILTER;
        end
      end
      FILTER: begin
        acc_d = acc_q + prod_x;
        k_d   = k_q + 1'b1;
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = ERR;
        end
      end
      ERR: begin
        e_d         = e_new;
        data_out_d  = e_new;
        out_valid_d = 1'b1;
        k_d         = '0;
        state_d     = UPDATE;
      end
      UPDATE: begin
        if (!frz) w_d[k_q] = w_new;
        k_d = k_q + 1'b1;
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      k_q         <= '0;
      x_q         <= '{default: '0};
      w_q         <= '{default: '0};
      acc_q       <= '0;
      dlat_q      <= '0;
      e_q         <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      x_q         <= x_d;
      w_q         <= w_d;
      acc_q       <= acc_d;
      dlat_q      <= dlat_d;
      e_q         <= e_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_lms_canceller.sv
// tb/tb_lms_canceller.sv - directed bench for lms_canceller
// Uses MU_SHIFT=4 so the sine convergence fits a short run; directed values are computed for that step.
module tb_lms_canceller;

  localparam int TAPS = 8;
  localparam int MU   = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic signed [23:0] d_in;
  logic signed [23:0] ref_in;
  logic               in_ready;
  logic signed [23:0] data_out;
  logic               out_valid;
  logic               overrun;
`ifdef LMS_FREEZE_EN
  logic               freeze;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lms_canceller #(.TAPS(TAPS), .MU_SHIFT(MU)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .d_in     (d_in),
    .ref_in   (ref_in),
`ifdef LMS_FREEZE_EN
    .freeze   (freeze),
`endif
    .in_ready (in_ready),
    .data_out (data_out),
    .out_valid(out_valid),
    .overrun  (overrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sine_at(input int idx);
    return int'(6000000.0 * $sin(2.0 * 3.14159265358979 * idx / 40.0));
  endfunction

  // Offers one sample, optionally pulses a junk in_valid on tick inj_at, and waits (bounded) for in_ready.
  task automatic do_sample(input int d, input int r, input int inj_at,
                           output logic signed [23:0] e, output int lat, output int rdy,
                           output int np, output logic busy0);
    in_valid = 1'b1;
    d_in     = 24'(d);
    ref_in   = 24'(r);
    tick();
    in_valid = 1'b0;
    busy0    = in_ready;
    lat      = -1;
    rdy      = -1;
    np       = 0;
    e        = 'x;
    for (int t = 1; t <= 64 && rdy < 0; t++) begin
      if (t == inj_at) begin
        in_valid = 1'b1;
        d_in     = -24'sd5000000;
        ref_in   = 24'sd8000000;
      end
      tick();
      in_valid = 1'b0;
      if (out_valid) begin
        np++;
        if (lat < 0) begin
          lat = t;
          e   = data_out;
        end
      end
      if (in_ready && rdy < 0) rdy = t;
    end
  endtask

  task automatic sine_run(input int count, input int settle, input bit passthru);
    logic signed [23:0] e;
    int lat, rdy, np, s;
    logic b0;
    for (int n = 0; n < count; n++) begin
      s = sine_at(n % 40);
      do_sample(s, s, 0, e, lat, rdy, np, b0);
      if (n == 0 || passthru) check("sine_e_equals_d", e, s);
      if (!passthru && n >= settle) check("sine_converged", ((e < 60000) && (e > -60000)) ? 1 : 0, 1);
      tick();
      tick();
    end
  endtask

  initial begin
    logic signed [23:0] e;
    int lat, rdy, np;
    logic b0;

    reset    = 1'b1;
    in_valid = 1'b0;
    d_in     = '0;
    ref_in   = '0;
`ifdef LMS_FREEZE_EN
    freeze   = 1'b0;
`endif
    tick();
    tick();
    reset = 1'b0;
    check("rst_data_out", data_out, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_in_ready", in_ready, 1);

    // First sample with zero weights: e = d, latency TAPS+1, ready again after 2*TAPS+1.
    do_sample(1000, 6000000, 0, e, lat, rdy, np, b0);
    check("s1_busy", b0, 0);
    check("s1_e", e, 1000);
    check("s1_latency", lat, TAPS + 1);
    check("s1_pulses", np, 1);
    check("s1_ready", rdy, 2 * TAPS + 1);
    tick();

    // Junk in_valid 3 clocks after acceptance must be dropped and flagged.
    do_sample(2000, 0, 3, e, lat, rdy, np, b0);
    check("s2_e", e, 2000);
    check("s2_overrun", overrun, 1);
    check("s2_pulses", np, 1);
    do_sample(3000, 0, 0, e, lat, rdy, np, b0);
    check("s3_e", e, 3000);
    check("s3_overrun_sticky", overrun, 1);
    do_sample(0, -4194304, 0, e, lat, rdy, np, b0);
    check("s4_e", e, 22);
    do_sample(0, 0, 0, e, lat, rdy, np, b0);
    check("s5_e_floor", e, 45);
    do_sample(0, 8388607, 0, e, lat, rdy, np, b0);
    check("s6_e", e, 25);
    check("s6_overrun_sticky", overrun, 1);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_overrun", overrun, 0);
    check("rst2_data_out", data_out, 0);

    sine_run(1210, 600, 1'b0);
    check("sine_no_overrun", overrun, 0);

    // Converged y is near +6e6, so d = -8388608 must clamp rather than wrap.
    do_sample(-8388608, sine_at(10), 0, e, lat, rdy, np, b0);
    check("sat_e", e, -8388608);
    check("sat_data_out_hold", data_out, -8388608);
    tick();
    tick();

    // Reset while in UPDATE.
    in_valid = 1'b1;
    d_in     = 24'(sine_at(11));
    ref_in   = 24'(sine_at(11));
    tick();
    in_valid = 1'b0;
    repeat (TAPS + 4) tick();
    check("pre_rst_busy", in_ready, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst3_data_out", data_out, 0);
    check("rst3_out_valid", out_valid, 0);
    check("rst3_in_ready", in_ready, 1);
    check("rst3_overrun", overrun, 0);
    do_sample(500, 6000000, 0, e, lat, rdy, np, b0);
    check("rst3_e", e, 500);
    do_sample(0, 0, 0, e, lat, rdy, np, b0);
    check("rst3_delay_cleared", e, 0);

`ifdef LMS_FREEZE_EN
    reset = 1'b1;
    tick();
    reset  = 1'b0;
    freeze = 1'b1;
    sine_run(100, 0, 1'b1);
    freeze = 1'b0;
    sine_run(900, 600, 1'b0);
    check("frz_no_overrun", overrun, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
